// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcode bit positions, FSM states,
// iteration counts and a one-hot test helper.
package alu_seq_pkg;

  localparam int unsigned OP_W   = 12;
  localparam int unsigned OP_ADD = 0;
  localparam int unsigned OP_SUB = 1;
  localparam int unsigned OP_MUL = 2;
  localparam int unsigned OP_DIV = 3;
  localparam int unsigned OP_SHR = 4;
  localparam int unsigned OP_SHL = 5;
  localparam int unsigned OP_ROR = 6;
  localparam int unsigned OP_ROL = 7;
  localparam int unsigned OP_AND = 8;
  localparam int unsigned OP_OR  = 9;
  localparam int unsigned OP_NEG = 10;
  localparam int unsigned OP_NOT = 11;

  localparam int unsigned MUL_ITER = 16;
  localparam int unsigned DIV_ITER = 32;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    MUL,
    DIV,
    DONE
  } state_e;

  function automatic logic is_onehot(input logic [OP_W-1:0] v);
    return (v != '0) && ((v & (v - 12'd1)) == '0);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle of the sequential ALU; master drives requests,
// slave (the ALU) returns registered results.
interface alu_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] alu_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] zlow;
  logic [31:0] zhigh;
  logic        op_err;

  modport master (
    output in_valid, alu_op, op_a, op_b, out_ready,
    input  in_ready, out_valid, zlow, zhigh, op_err
  );

  modport slave (
    input  in_valid, alu_op, op_a, op_b, out_ready,
    output in_ready, out_valid, zlow, zhigh, op_err
  );
endinterface

// File: rtl/alu_seq_muldiv.sv
// Iterative engine: signed radix-4 Booth multiply (16 steps) and, when
// ALU_SEQ_DIV_EN is defined, unsigned restoring divide (32 steps).
module alu_seq_muldiv
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        mode_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        done_o,
  output logic [63:0] result_o
);

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] mcand_q, mcand_d;
  logic [32:0] mq_q, mq_d;
  logic [63:0] pp;
  logic [5:0]  last;
  logic        go;
`ifdef ALU_SEQ_DIV_EN
  logic        mode_q, mode_d;
  logic [32:0] sh, diff;

  assign go = start_i;
`else
  assign go = start_i & ~mode_i;
`endif

  always_comb begin
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mq_d    = mq_q;
    pp      = '0;
`ifdef ALU_SEQ_DIV_EN
    mode_d  = mode_q;
    sh      = '0;
    diff    = '0;
    last    = mode_q ? 6'(DIV_ITER - 1) : 6'(MUL_ITER - 1);
`else
    last    = 6'(MUL_ITER - 1);
`endif
    if (go) begin
      busy_d = 1'b1;
      cnt_d  = '0;
`ifdef ALU_SEQ_DIV_EN
      mode_d = mode_i;
      // Divide keeps remainder:quotient in acc; divisor sits in mcand[31:0].
      if (mode_i) begin
        acc_d   = {32'd0, a_i};
        mcand_d = {32'd0, b_i};
        mq_d    = '0;
      end else
`endif
      begin
        acc_d   = '0;
        mcand_d = {{32{a_i[31]}}, a_i};
        mq_d    = {b_i, 1'b0};
      end
    end else if (busy_q) begin
      cnt_d = cnt_q + 6'd1;
      if (cnt_q == last) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
`ifdef ALU_SEQ_DIV_EN
      // A zero divisor never borrows, so quotient saturates to all ones and
      // the dividend shifts through unchanged into the remainder.
      if (mode_q) begin
        sh   = {acc_q[63:32], acc_q[31]};
        diff = sh - {1'b0, mcand_q[31:0]};
        if (!diff[32]) acc_d = {diff[31:0], acc_q[30:0], 1'b1};
        else           acc_d = {sh[31:0],   acc_q[30:0], 1'b0};
      end else
`endif
      begin
        case (mq_q[2:0])
          3'b001, 3'b010: pp = mcand_q;
          3'b011:         pp = mcand_q << 1;
          3'b100:         pp = -(mcand_q << 1);
          3'b101, 3'b110: pp = -mcand_q;
          default:        pp = '0;
        endcase
        acc_d   = acc_q + pp;
        mcand_d = mcand_q << 2;
        mq_d    = {{2{mq_q[32]}}, mq_q[32:2]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      mq_q    <= '0;
`ifdef ALU_SEQ_DIV_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mq_q    <= mq_d;
`ifdef ALU_SEQ_DIV_EN
      mode_q  <= mode_d;
`endif
    end
  end

  assign done_o   = done_q;
  assign result_o = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU top: request FSM, single-cycle ops and registered result.
// Divide support depends on ALU_SEQ_DIV_EN; otherwise DIV reports op_err.
module alu_seq
  import alu_seq_pkg::*;
(
  input  logic       clock,
  input  logic       clear_n,
  alu_seq_if.slave   bus
);

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [31:0]     a_q, a_d, b_q, b_d;
  logic [31:0]     zlow_q, zlow_d, zhigh_q, zhigh_d;
  logic            err_q, err_d;

  logic        md_start, md_mode, md_done;
  logic [63:0] md_result;

  logic [31:0] ex_lo, ex_hi, neg_b;
  logic        ex_err;
  logic [32:0] sum;
  logic [63:0] rot;

  alu_seq_muldiv u_muldiv (
    .clk      (clock),
    .rst_n    (clear_n),
    .start_i  (md_start),
    .mode_i   (md_mode),
    .a_i      (bus.op_a),
    .b_i      (bus.op_b),
    .done_o   (md_done),
    .result_o (md_result)
  );

  always_comb begin
    ex_lo  = '0;
    ex_hi  = '0;
    ex_err = 1'b0;
    sum    = '0;
    rot    = '0;
    neg_b  = ~b_q + 32'd1;
    if (!is_onehot(op_q)) begin
      ex_err = 1'b1;
    end else begin
      unique case (1'b1)
        op_q[OP_ADD]: begin
          sum   = {1'b0, a_q} + {1'b0, b_q};
          ex_lo = sum[31:0];
          ex_hi = {31'd0, sum[32]};
        end
        op_q[OP_SUB]: begin
          sum   = {1'b0, a_q} + {1'b0, neg_b};
          ex_lo = sum[31:0];
          ex_hi = {31'd0, sum[32]};
        end
        op_q[OP_SHR]: ex_lo = (|b_q[31:5]) ? '0 : a_q >> b_q[4:0];
        op_q[OP_SHL]: ex_lo = (|b_q[31:5]) ? '0 : a_q << b_q[4:0];
        op_q[OP_ROR]: begin
          rot   = {a_q, a_q} >> b_q[4:0];
          ex_lo = rot[31:0];
        end
        op_q[OP_ROL]: begin
          rot   = {a_q, a_q} << b_q[4:0];
          ex_lo = rot[63:32];
        end
        op_q[OP_AND]: ex_lo = a_q & b_q;
        op_q[OP_OR]:  ex_lo = a_q | b_q;
        op_q[OP_NEG]: ex_lo = neg_b;
        op_q[OP_NOT]: ex_lo = ~b_q;
        default:      ex_err = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    zlow_d   = zlow_q;
    zhigh_d  = zhigh_q;
    err_d    = err_q;
    md_start = 1'b0;
    md_mode  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d = bus.alu_op;
          a_d  = bus.op_a;
          b_d  = bus.op_b;
          if (is_onehot(bus.alu_op) && bus.alu_op[OP_MUL]) begin
            state_d  = MUL;
            md_start = 1'b1;
`ifdef ALU_SEQ_DIV_EN
          end else if (is_onehot(bus.alu_op) && bus.alu_op[OP_DIV]) begin
            state_d  = DIV;
            md_start = 1'b1;
            md_mode  = 1'b1;
`endif
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        zlow_d  = ex_lo;
        zhigh_d = ex_hi;
        err_d   = ex_err;
        state_d = DONE;
      end
      MUL, DIV: begin
        if (md_done) begin
          zlow_d  = md_result[31:0];
          zhigh_d = md_result[63:32];
          err_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      zlow_q  <= '0;
      zhigh_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      zlow_q  <= zlow_d;
      zhigh_q <= zhigh_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.zlow      = zlow_q;
  assign bus.zhigh     = zhigh_q;
  assign bus.op_err    = err_q;

endmodule
